// File: rtl/m_registers.sv
// Remainder (R), divisor (D) and quotient (Z) registers of the iterative M-unit divider.
// Each register follows its own 2-bit selector; all outputs are registered.
module m_registers (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  mux_R,
  input  logic [1:0]  mux_D,
  input  logic [1:0]  mux_Z,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] sub_result,
  input  logic        sub_neg,
  output logic [31:0] R,
  output logic [62:0] D,
  output logic [31:0] Z
);

  localparam int unsigned MUX_R_LENGTH = 2;
  localparam int unsigned MUX_D_LENGTH = 2;
  localparam int unsigned MUX_Z_LENGTH = 2;

  localparam logic [MUX_R_LENGTH-1:0] MUX_R_KEEP     = 2'd0;
  localparam logic [MUX_R_LENGTH-1:0] MUX_R_A        = 2'd1;
  localparam logic [MUX_R_LENGTH-1:0] MUX_R_A_NEG    = 2'd2;
  localparam logic [MUX_R_LENGTH-1:0] MUX_R_SUB_KEEP = 2'd3;

  localparam logic [MUX_D_LENGTH-1:0] MUX_D_KEEP  = 2'd0;
  localparam logic [MUX_D_LENGTH-1:0] MUX_D_B     = 2'd1;
  localparam logic [MUX_D_LENGTH-1:0] MUX_D_B_NEG = 2'd2;
  localparam logic [MUX_D_LENGTH-1:0] MUX_D_SHR   = 2'd3;

  localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_KEEP    = 2'd0;
  localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_ZERO    = 2'd1;
  localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_SHL_ADD = 2'd2;

  // Two's-complement negation modulo 2^32 (0x80000000 maps to itself).
  function automatic logic [31:0] neg32(input logic [31:0] v);
    neg32 = (~v) + 32'd1;
  endfunction

  logic [31:0] r_rem;
  logic [62:0] r_div;
  logic [31:0] r_quo;
  logic [31:0] w_rem_next;
  logic [62:0] w_div_next;
  logic [31:0] w_quo_next;

  // Next-state selection for the three registers, each driven only by its own selector.
  always_comb begin
    w_rem_next = r_rem;
    w_div_next = r_div;
    w_quo_next = r_quo;

    case (mux_R)
      MUX_R_KEEP:  w_rem_next = r_rem;
      MUX_R_A:     w_rem_next = rs1;
      MUX_R_A_NEG: w_rem_next = neg32(rs1);
      MUX_R_SUB_KEEP: begin
        if (!sub_neg) begin
          w_rem_next = sub_result;
        end else begin
          w_rem_next = r_rem;
        end
      end
      default:     w_rem_next = r_rem;
    endcase

    case (mux_D)
      MUX_D_KEEP:  w_div_next = r_div;
      MUX_D_B:     w_div_next = {rs2, 31'd0};
      MUX_D_B_NEG: w_div_next = {neg32(rs2), 31'd0};
      MUX_D_SHR:   w_div_next = {1'b0, r_div[62:1]};
      default:     w_div_next = r_div;
    endcase

    case (mux_Z)
      MUX_Z_KEEP:    w_quo_next = r_quo;
      MUX_Z_ZERO:    w_quo_next = 32'd0;
      MUX_Z_SHL_ADD: w_quo_next = {r_quo[30:0], ~sub_neg};
      default:       w_quo_next = r_quo;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rem <= 32'd0;
      r_div <= 63'd0;
      r_quo <= 32'd0;
    end else begin
      r_rem <= w_rem_next;
      r_div <= w_div_next;
      r_quo <= w_quo_next;
    end
  end

  assign R = r_rem;
  assign D = r_div;
  assign Z = r_quo;

endmodule

// File: tb/tb_m_registers.sv
// Self-checking bench for m_registers: a directed vector table plus
// hand-written reset, long-shift and quotient-overflow sequences.
module tb_m_registers;

  logic        clk;
  logic        resetn;
  logic [1:0]  mux_R;
  logic [1:0]  mux_D;
  logic [1:0]  mux_Z;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] sub_result;
  logic        sub_neg;
  logic [31:0] R;
  logic [62:0] D;
  logic [31:0] Z;

  int n_cmp;
  int n_bad;

  m_registers dut (
    .clk        (clk),
    .resetn     (resetn),
    .mux_R      (mux_R),
    .mux_D      (mux_D),
    .mux_Z      (mux_Z),
    .rs1        (rs1),
    .rs2        (rs2),
    .sub_result (sub_result),
    .sub_neg    (sub_neg),
    .R          (R),
    .D          (D),
    .Z          (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mr;
    logic [1:0]  md;
    logic [1:0]  mz;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sr;
    logic        sn;
    logic [31:0] exp_r;
    logic [62:0] exp_d;
    logic [31:0] exp_z;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] mr, input logic [1:0] md, input logic [1:0] mz,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] sr, input logic sn);
    mux_R = mr; mux_D = md; mux_Z = mz;
    rs1 = a; rs2 = b; sub_result = sr; sub_neg = sn;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // R: 0 KEEP 1 A 2 A_NEG 3 SUB_KEEP; D: 0 KEEP 1 B 2 B_NEG 3 SHR; Z: 0 KEEP 1 ZERO 2 SHL_ADD
    vecs[0] = '{2'd1, 2'd1, 2'd1, 32'd789, 32'd456, 32'd0, 1'b0,
                32'd789, {32'd456, 31'd0}, 32'd0};
    vecs[1] = '{2'd2, 2'd0, 2'd2, 32'hFFFF_E12E, 32'd0, 32'd0, 1'b0,
                32'd7890, {32'd456, 31'd0}, 32'd1};
    vecs[2] = '{2'd0, 2'd2, 2'd0, 32'd0, 32'hFFFF_EE29, 32'd55, 1'b1,
                32'd7890, {32'd4567, 31'd0}, 32'd1};
    vecs[3] = '{2'd3, 2'd3, 2'd2, 32'd0, 32'd0, 32'hFFFF_FF85, 1'b1,
                32'd7890, {1'b0, 32'd4567, 30'd0}, 32'd2};
    vecs[4] = '{2'd3, 2'd0, 2'd2, 32'd0, 32'd0, 32'd123, 1'b0,
                32'd123, {1'b0, 32'd4567, 30'd0}, 32'd5};
    vecs[5] = '{2'd0, 2'd0, 2'd2, 32'd0, 32'd0, 32'd999, 1'b0,
                32'd123, {1'b0, 32'd4567, 30'd0}, 32'd11};
    vecs[6] = '{2'd3, 2'd3, 2'd2, 32'd0, 32'd0, 32'h8000_0000, 1'b1,
                32'd123, {2'b00, 32'd4567, 29'd0}, 32'd22};
    vecs[7] = '{2'd2, 2'd2, 2'd3, 32'h8000_0000, 32'd0, 32'd0, 1'b0,
                32'h8000_0000, 63'd0, 32'd22};
    vecs[8] = '{2'd2, 2'd1, 2'd1, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b0,
                32'd0, {32'hFFFF_FFFF, 31'd0}, 32'd0};
    vecs[9] = '{2'd1, 2'd3, 2'd2, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b0,
                32'hDEAD_BEEF, {1'b0, 32'hFFFF_FFFF, 30'd0}, 32'd1};

    drive(2'd1, 2'd1, 2'd2, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1111_1111, 1'b0);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_R", {32'd0, R}, 64'd0);
    check("reset_D", {1'b0, D}, 64'd0);
    check("reset_Z", {32'd0, Z}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].mr, vecs[i].md, vecs[i].mz, vecs[i].a, vecs[i].b, vecs[i].sr, vecs[i].sn);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_R", i), {32'd0, R}, {32'd0, vecs[i].exp_r});
      check($sformatf("vec%0d_D", i), {1'b0, D}, {1'b0, vecs[i].exp_d});
      check($sformatf("vec%0d_Z", i), {32'd0, Z}, {32'd0, vecs[i].exp_z});
    end

    // Quotient shifts: 32 ones fill Z, then a zero bit pushes the MSB out.
    drive(2'd0, 2'd1, 2'd1, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    mux_Z = 2'd2;
    mux_D = 2'd3;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
    end
    #1;
    check("z_all_ones", {32'd0, Z}, {32'd0, 32'hFFFF_FFFF});
    check("d_shr32", {1'b0, D}, {1'b0, 32'd0, 31'h7FFF_FFFF});
    sub_neg = 1'b1;
    @(posedge clk);
    #1;
    check("z_msb_drop", {32'd0, Z}, {32'd0, 32'hFFFF_FFFE});
    mux_Z = 2'd0;
    for (int i = 0; i < 29; i++) begin
      @(posedge clk);
    end
    #1;
    check("d_shr62", {1'b0, D}, 64'd1);
    @(posedge clk);
    #1;
    check("d_shr63", {1'b0, D}, 64'd0);

    // Asynchronous reset between edges with nonzero state.
    drive(2'd1, 2'd1, 2'd1, 32'hCAFE_0001, 32'd77, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    mux_Z = 2'd2;
    @(posedge clk);
    #3;
    check("pre_rst_R", {32'd0, R}, {32'd0, 32'hCAFE_0001});
    resetn = 1'b0;
    #1;
    check("async_rst_R", {32'd0, R}, 64'd0);
    check("async_rst_D", {1'b0, D}, 64'd0);
    check("async_rst_Z", {32'd0, Z}, 64'd0);
    drive(2'd1, 2'd1, 2'd2, 32'd5, 32'd3, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    check("held_rst_Z", {32'd0, Z}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_R", {32'd0, R}, 64'd5);
    check("post_rst_D", {1'b0, D}, {1'b0, 32'd3, 31'd0});
    check("post_rst_Z", {32'd0, Z}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
